// File: rtl/am_query_engine.sv
// Associative-memory query engine: segment-serial AND/popcount against every class HV, then argmax.
// Optional accuracy tally counters are built when AM_ACC_TALLY_EN is defined.
module am_query_engine #(
    parameter int unsigned HV_DIM      = 5120,
    parameter int unsigned DIMS_PER_CC = 512,
    parameter int unsigned NUM_CLASSES = 26,
    parameter int unsigned CLASS_W     = $clog2(NUM_CLASSES),
    parameter int unsigned SIM_W       = $clog2(HV_DIM + 1)
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            en,
    input  logic                            q_valid,
    output logic                            q_ready,
    input  logic [HV_DIM-1:0]               q_hv,
    input  logic [CLASS_W-1:0]              q_label,
    input  logic [NUM_CLASSES*HV_DIM-1:0]   class_hvs,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [CLASS_W-1:0]              res_class,
    output logic [SIM_W-1:0]                res_sim,
    input  logic                            tally_clr,
    output logic [15:0]                     correct_cnt,
    output logic [15:0]                     total_cnt
);

    localparam int unsigned SEQ_CC = HV_DIM / DIMS_PER_CC;
    localparam int unsigned SEG_W  = (SEQ_CC > 1) ? $clog2(SEQ_CC) : 1;

    if (HV_DIM % DIMS_PER_CC != 0) begin : g_bad_seg
        $error("HV_DIM must be a multiple of DIMS_PER_CC");
    end
    if (NUM_CLASSES < 2) begin : g_bad_classes
        $error("NUM_CLASSES must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StArgmax, StDone} state_e;

    state_e state_q, state_d;

    logic accept, acc_step, argmax_load, res_hs, seg_last;

    logic [SEG_W-1:0]   seg_q;
    logic [SIM_W-1:0]   acc_q [NUM_CLASSES];
    logic [SIM_W-1:0]   seg_pop [NUM_CLASSES];
    logic [CLASS_W-1:0] res_class_q, best_class;
    logic [SIM_W-1:0]   res_sim_q, best_sim;

    // Packed views let the current segment be selected by seg_q directly.
    logic [SEQ_CC-1:0][DIMS_PER_CC-1:0]                  q_segs_q;
    logic [NUM_CLASSES-1:0][SEQ_CC-1:0][DIMS_PER_CC-1:0] cls_segs;

    assign cls_segs = class_hvs;
    assign seg_last = (seg_q == SEG_W'(SEQ_CC - 1));

    // State register
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= StIdle;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (q_valid)   state_d = StAccum;
            StAccum:  if (seg_last)  state_d = StArgmax;
            StArgmax:                state_d = StDone;
            StDone:   if (res_ready) state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    // Outputs and datapath strobes
    always_comb begin
        q_ready     = en && (state_q == StIdle);
        res_valid   = (state_q == StDone);
        accept      = q_valid && q_ready;
        acc_step    = en && (state_q == StAccum);
        argmax_load = en && (state_q == StArgmax);
        res_hs      = en && res_valid && res_ready;
    end

    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            seg_pop[c] = SIM_W'($countones(q_segs_q[seg_q] & cls_segs[c][seg_q]));
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_class = '0;
        best_sim   = acc_q[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (acc_q[c] > best_sim) begin
                best_sim   = acc_q[c];
                best_class = CLASS_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst && accept) begin
            q_segs_q <= q_hv;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            seg_q       <= '0;
            res_class_q <= '0;
            res_sim_q   <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            if (accept) begin
                seg_q <= '0;
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    acc_q[c] <= '0;
                end
            end
            if (acc_step) begin
                seg_q <= seg_q + SEG_W'(1);
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    acc_q[c] <= acc_q[c] + seg_pop[c];
                end
            end
            if (argmax_load) begin
                res_class_q <= best_class;
                res_sim_q   <= best_sim;
            end
        end
    end

    assign res_class = res_class_q;
    assign res_sim   = res_sim_q;

`ifdef AM_ACC_TALLY_EN
    logic [CLASS_W-1:0] label_q;
    logic [15:0]        correct_q, total_q;

    always_ff @(posedge clk) begin
        if (!nrst && accept) begin
            label_q <= q_label;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            correct_q <= '0;
            total_q   <= '0;
        end else if (en) begin
            if (tally_clr) begin
                correct_q <= '0;
                total_q   <= '0;
            end else if (res_hs) begin
                if (total_q != 16'hFFFF) begin
                    total_q <= total_q + 16'd1;
                end
                if ((res_class_q == label_q) && (correct_q != 16'hFFFF)) begin
                    correct_q <= correct_q + 16'd1;
                end
            end
        end
    end

    assign correct_cnt = correct_q;
    assign total_cnt   = total_q;
`else
    logic unused_tally;
    assign unused_tally = ^{q_label, tally_clr, res_hs};
    assign correct_cnt  = '0;
    assign total_cnt    = '0;
`endif

endmodule

// File: tb/tb_am_query_engine.sv
// Randomized self-checking bench for am_query_engine with a whole-vector behavioural model.
module tb_am_query_engine;

    localparam int HV_DIM  = 5120;
    localparam int DPC     = 512;
    localparam int NC      = 26;
    localparam int CLASS_W = 5;
    localparam int SIM_W   = 13;
    localparam int SEQ_CC  = HV_DIM / DPC;

    logic                   clk = 1'b0;
    logic                   nrst, en, q_valid, q_ready, res_valid, res_ready, tally_clr;
    logic [HV_DIM-1:0]      q_hv;
    logic [CLASS_W-1:0]     q_label, res_class;
    logic [SIM_W-1:0]       res_sim;
    logic [NC*HV_DIM-1:0]   class_hvs;
    logic [15:0]            correct_cnt, total_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int model_correct = 0;
    int model_total   = 0;

    always #5 clk = ~clk;

    am_query_engine #(
        .HV_DIM      (HV_DIM),
        .DIMS_PER_CC (DPC),
        .NUM_CLASSES (NC)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .q_hv        (q_hv),
        .q_label     (q_label),
        .class_hvs   (class_hvs),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_class   (res_class),
        .res_sim     (res_sim),
        .tally_clr   (tally_clr),
        .correct_cnt (correct_cnt),
        .total_cnt   (total_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [HV_DIM-1:0] get_class(input int c);
        return class_hvs[c*HV_DIM +: HV_DIM];
    endfunction

    task automatic rand_hv(output logic [HV_DIM-1:0] v);
        for (int i = 0; i < HV_DIM / 32; i++) v[i*32 +: 32] = $urandom;
    endtask

    task automatic rand_classes();
        logic [HV_DIM-1:0] tmp;
        for (int c = 0; c < NC; c++) begin
            rand_hv(tmp);
            class_hvs[c*HV_DIM +: HV_DIM] = tmp;
        end
    endtask

    // Full-vector similarity per class; first maximum wins.
    task automatic model(input logic [HV_DIM-1:0] qv, output int cls, output int sim);
        int s;
        cls = 0;
        sim = -1;
        for (int c = 0; c < NC; c++) begin
            s = $countones(qv & get_class(c));
            if (s > sim) begin
                sim = s;
                cls = c;
            end
        end
    endtask

    task automatic run_query(input logic [HV_DIM-1:0] qv, input int lbl, input int stall_at,
                             input int stall_len, input int hold, input bit clr);
        int exp_cls, exp_sim, k;
        model(qv, exp_cls, exp_sim);
        @(negedge clk);
        check_eq("q_ready_idle", q_ready, 1);
        q_hv    = qv;
        q_label = CLASS_W'(lbl);
        q_valid = 1'b1;
        @(posedge clk);
        #1 q_valid = 1'b0;
        q_hv = '0;
        @(negedge clk);
        k = 0;
        while (!res_valid && k < 200) begin
            @(negedge clk);
            k++;
            if (stall_len > 0 && k == stall_at) en = 1'b0;
            if (stall_len > 0 && k == stall_at + stall_len) en = 1'b1;
        end
        en = 1'b1;
        check_eq("latency", k, SEQ_CC + 1 + stall_len);
        check_eq("res_class", res_class, exp_cls);
        check_eq("res_sim", res_sim, exp_sim);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_stable", {res_valid, q_ready, res_class, res_sim},
                     {1'b1, 1'b0, CLASS_W'(exp_cls), SIM_W'(exp_sim)});
        end
        en        = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check_eq("done_en_low", res_valid, 1);
        en        = 1'b1;
        tally_clr = clr;
        @(posedge clk);
        #1 res_ready = 1'b0;
        tally_clr = 1'b0;
`ifdef AM_ACC_TALLY_EN
        if (clr) begin
            model_correct = 0;
            model_total   = 0;
        end else begin
            model_total++;
            if (exp_cls == lbl) model_correct++;
        end
`endif
        @(negedge clk);
        check_eq("res_valid_drop", res_valid, 0);
        check_eq("correct_cnt", correct_cnt, model_correct);
        check_eq("total_cnt", total_cnt, model_total);
    endtask

    initial begin
        logic [HV_DIM-1:0] qv;
        int cls, sim;
        nrst      = 1'b1;
        en        = 1'b1;
        q_valid   = 1'b0;
        res_ready = 1'b0;
        tally_clr = 1'b0;
        q_hv      = '0;
        q_label   = '0;
        rand_classes();
        repeat (3) @(posedge clk);
        #1 nrst = 1'b0;
        @(negedge clk);
        check_eq("rst_q_ready", q_ready, 1);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_class", res_class, 0);
        check_eq("rst_res_sim", res_sim, 0);
        check_eq("rst_correct", correct_cnt, 0);
        check_eq("rst_total", total_cnt, 0);

        // Query equal to class 7, result held for 20 cycles.
        run_query(get_class(7), 7, 0, 0, 20, 1'b0);
        check_eq("class7_sim", res_sim, $countones(get_class(7)));

        // Identical classes 3 and 9: lowest index wins.
        class_hvs[9*HV_DIM +: HV_DIM] = get_class(3);
        run_query(get_class(3), 3, 0, 0, 0, 1'b0);

        // Five-cycle enable stall in the middle of accumulation.
        rand_classes();
        rand_hv(qv);
        run_query(qv, 0, 3, 5, 2, 1'b0);

        // Reset at segment 4 abandons the query.
        rand_hv(qv);
        @(negedge clk);
        q_hv    = qv;
        q_valid = 1'b1;
        @(posedge clk);
        #1 q_valid = 1'b0;
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1 nrst = 1'b0;
        @(negedge clk);
        check_eq("midrst_res_valid", res_valid, 0);
        check_eq("midrst_q_ready", q_ready, 1);
        model_correct = 0;
        model_total   = 0;
        rand_hv(qv);
        run_query(qv, 1, 0, 0, 0, 1'b0);

        // Clear coincident with a handshake.
        rand_hv(qv);
        run_query(qv, 0, 0, 0, 0, 1'b1);
        check_eq("clr_correct", correct_cnt, 0);
        check_eq("clr_total", total_cnt, 0);

        // Ten queries, seven with matching labels.
        for (int i = 0; i < 10; i++) begin
            rand_hv(qv);
            model(qv, cls, sim);
            run_query(qv, (i < 7) ? cls : (cls + 1) % NC, 0, 0, 0, 1'b0);
        end
`ifdef AM_ACC_TALLY_EN
        check_eq("tally10_correct", correct_cnt, 7);
        check_eq("tally10_total", total_cnt, 10);
`else
        check_eq("tally_off_correct", correct_cnt, 0);
        check_eq("tally_off_total", total_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
